// File: rtl/aes_sbox_pkg.sv
// Shared types for the S-box bank scheduler: job owner, in-flight tag,
// scheduler state and column helpers for the 128-bit AES state.
package aes_sbox_pkg;

    localparam int unsigned NUM_COL = 4;

    typedef enum logic {
        OWN_KEY = 1'b0,
        OWN_DAT = 1'b1
    } owner_e;

    typedef struct packed {
        logic       valid;
        owner_e     owner;
        logic [1:0] col;
    } sbox_tag_t;

    typedef enum logic {
        IDLE      = 1'b0,
        DAT_ISSUE = 1'b1
    } sched_state_e;

    localparam sbox_tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_KEY, col: 2'd0};

    // Column 0 lives in the most significant word of the state.
    function automatic logic [31:0] col_of(input logic [127:0] st, input logic [1:0] c);
        logic [31:0] w;
        case (c)
            2'd0:    w = st[127:96];
            2'd1:    w = st[95:64];
            2'd2:    w = st[63:32];
            default: w = st[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [127:0] put_col(input logic [127:0] st, input logic [1:0] c,
                                             input logic [31:0] w);
        logic [127:0] r;
        r = st;
        case (c)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sbox_tag_pipe.sv
// Shift register of in-flight tags that tracks words through the S-box bank.
module sbox_tag_pipe
    import aes_sbox_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  sbox_tag_t tag_in,
    output sbox_tag_t tag_out,
    output logic      any_valid
);

    sbox_tag_t stage [DEPTH];

    // Advance every tag one stage per cycle; reset drops all in-flight tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= TAG_NONE;
            end
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // Any stage holding a live tag means a word is still inside the bank.
    always_comb begin
        any_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage[i].valid;
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/sbox_share_scheduler.sv
// Time-shares the external four-lane S-box bank between SubWord (key) and
// SubBytes (data) jobs and routes each returning word to its owner.
module sbox_share_scheduler
    import aes_sbox_pkg::*;
#(
    parameter int unsigned SBOX_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_req_valid,
    input  logic [31:0]  key_req_word,
    output logic         key_req_ready,
    output logic         key_rsp_valid,
    output logic [31:0]  key_rsp_word,
    input  logic         dat_req_valid,
    input  logic [127:0] dat_req_state,
    output logic         dat_req_ready,
    output logic         dat_rsp_valid,
    output logic [127:0] dat_rsp_state,
    output logic         sbox_in_valid,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out,
    output logic         busy
);

    sched_state_e state;
    logic [1:0]   col;
    owner_e       last_grant;
    logic [127:0] hold;
    logic [127:0] collect;
    sbox_tag_t    issue_tag;
    sbox_tag_t    ret_tag;
    logic         pipe_busy;
    logic         grant_key;
    logic         grant_dat;

    // A lone requester wins; on a tie the path not served last time wins.
    always_comb begin
        grant_key = 1'b0;
        grant_dat = 1'b0;
        if (state == IDLE) begin
            if (key_req_valid && dat_req_valid) begin
                if (last_grant == OWN_DAT) grant_key = 1'b1;
                else                       grant_dat = 1'b1;
            end else if (key_req_valid) begin
                grant_key = 1'b1;
            end else if (dat_req_valid) begin
                grant_dat = 1'b1;
            end
        end
    end

    assign key_req_ready = grant_key;
    assign dat_req_ready = grant_dat;

    // Issue FSM: a key word goes out in one cycle, a data job holds the bank for four columns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            col           <= '0;
            last_grant    <= OWN_DAT;
            hold          <= '0;
            sbox_in       <= '0;
            sbox_in_valid <= 1'b0;
            issue_tag     <= TAG_NONE;
        end else begin
            sbox_in_valid <= 1'b0;
            issue_tag     <= TAG_NONE;
            case (state)
                IDLE: begin
                    if (grant_key) begin
                        sbox_in       <= key_req_word;
                        sbox_in_valid <= 1'b1;
                        issue_tag     <= '{valid: 1'b1, owner: OWN_KEY, col: 2'd0};
                        last_grant    <= OWN_KEY;
                    end else if (grant_dat) begin
                        hold          <= dat_req_state;
                        sbox_in       <= dat_req_state[127:96];
                        sbox_in_valid <= 1'b1;
                        issue_tag     <= '{valid: 1'b1, owner: OWN_DAT, col: 2'd0};
                        col           <= 2'd1;
                        last_grant    <= OWN_DAT;
                        state         <= DAT_ISSUE;
                    end
                end
                DAT_ISSUE: begin
                    sbox_in       <= col_of(hold, col);
                    sbox_in_valid <= 1'b1;
                    issue_tag     <= '{valid: 1'b1, owner: OWN_DAT, col: col};
                    col           <= col + 2'd1;
                    if (col == 2'd3) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sbox_tag_pipe #(
        .DEPTH (SBOX_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_in    (issue_tag),
        .tag_out   (ret_tag),
        .any_valid (pipe_busy)
    );

    // Return path: tag at the bank output decides who owns sbox_out this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_rsp_valid <= 1'b0;
            key_rsp_word  <= '0;
            dat_rsp_valid <= 1'b0;
            dat_rsp_state <= '0;
            collect       <= '0;
        end else begin
            key_rsp_valid <= 1'b0;
            dat_rsp_valid <= 1'b0;
            if (ret_tag.valid) begin
                if (ret_tag.owner == OWN_KEY) begin
                    key_rsp_word  <= sbox_out;
                    key_rsp_valid <= 1'b1;
                end else begin
                    collect <= put_col(collect, ret_tag.col, sbox_out);
                    // Column 3 is merged straight into the output so the pulse needs no extra cycle.
                    if (ret_tag.col == 2'd3) begin
                        dat_rsp_state <= put_col(collect, 2'd3, sbox_out);
                        dat_rsp_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy = (state != IDLE) | issue_tag.valid | pipe_busy;

endmodule
